// File: rtl/exec_seq_pkg.sv
// Shared opcodes, NOP encoding and sequencer state type for the EX issue stage.
// Also holds the source-register usage decode that the hazard check relies on.
package exec_seq_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    HALT
  } seq_state_t;

  function automatic logic uses_rs1(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_IMM, OP_BRANCH, OP_JALR: uses_rs1 = 1'b1;
      OP_JAL, OP_LUI, OP_AUIPC:         uses_rs1 = 1'b0;
      default:                          uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opcode);
    case (opcode)
      OP_R, OP_BRANCH: uses_rs2 = 1'b1;
      default:         uses_rs2 = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Read-after-write check of the fetched instruction against the live EX instruction.
// Only the low 25 instruction bits carry opcode and source fields.
module hazard_detect
  import exec_seq_pkg::*;
(
  input  logic [24:0] instr,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wen,
  output logic        stall
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = uses_rs1(instr[6:0]) && (instr[19:15] == ex_rd);
    rs2_hit = uses_rs2(instr[6:0]) && (instr[24:20] == ex_rd);
    stall   = ex_wen && (ex_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/exec_sequencer.sv
// EX issue register and sequencing FSM between fetch and the ALU/writeback.
// Handles RAW stalls, branch redirect with fetch flush, and error halt.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter int unsigned             INSTR_LENGTH = 32,
  parameter int unsigned             FLUSH_CYCLES = 2,
  parameter logic [INSTR_LENGTH-1:0] RESET_PC     = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [INSTR_LENGTH-1:0] if_instr,
  input  logic [INSTR_LENGTH-1:0] if_pc,
  output logic                    if_ready,
  output logic                    ex_valid,
  output logic [INSTR_LENGTH-1:0] ex_op,
  output logic [INSTR_LENGTH-1:0] ex_pc,
  input  logic                    alu_pc_jump,
  input  logic                    alu_not_relative_pc,
  input  logic [INSTR_LENGTH-1:0] alu_jump_offset,
  input  logic                    alu_w_mem,
  input  logic [1:0]              alu_err,
  output logic                    wb_en,
  output logic [4:0]              wb_rd,
  output logic                    redirect_valid,
  output logic [INSTR_LENGTH-1:0] redirect_pc,
  output logic                    halted
);

  localparam int unsigned CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned FLUSH_INIT = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam seq_state_t  JUMP_STATE = (FLUSH_CYCLES > 0) ? FLUSH : RUN;

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] flush_cnt;
  logic             stall;
  logic             take_err;
  logic             take_jump;
  logic             transfer;
  logic             unused_err_rsvd;

  // alu_err[1] is reserved and deliberately has no effect.
  assign unused_err_rsvd = alu_err[1];

  assign take_err  = ex_valid & alu_err[0];
  assign take_jump = ex_valid & alu_pc_jump & ~alu_err[0];

  hazard_detect u_hazard (
    .instr  (if_instr[24:0]),
    .ex_rd  (ex_op[11:7]),
    .ex_wen (ex_valid & alu_w_mem),
    .stall  (stall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= JUMP_STATE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (take_err)       state_nxt = HALT;
        else if (take_jump) state_nxt = JUMP_STATE;
      end
      FLUSH:   if (!redirect_valid && flush_cnt == '0) state_nxt = RUN;
      HALT:    state_nxt = HALT;
      default: state_nxt = HALT;
    endcase
  end

  // The cycle carrying the redirect pulse refuses fetch: its word predates the new PC.
  always_comb begin
    if_ready = 1'b0;
    transfer = 1'b0;
    halted   = 1'b0;
    case (state)
      RUN: begin
        if_ready = ~redirect_valid & ~stall & ~take_err & ~take_jump;
        transfer = if_ready & if_valid;
      end
      FLUSH:   if_ready = ~redirect_valid;
      HALT:    halted = 1'b1;
      default: halted = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_op          <= INSTR_LENGTH'(NOP_INSTR);
      ex_pc          <= '0;
      wb_en          <= 1'b0;
      wb_rd          <= '0;
      redirect_valid <= 1'b1;
      redirect_pc    <= RESET_PC;
      flush_cnt      <= CNT_W'(FLUSH_INIT);
    end else begin
      ex_valid <= transfer;
      if (transfer) begin
        ex_op <= if_instr;
        ex_pc <= if_pc;
      end else begin
        ex_op <= INSTR_LENGTH'(NOP_INSTR);
      end

      if (ex_valid) begin
        wb_rd <= ex_op[11:7];
        wb_en <= alu_w_mem & ~alu_err[0] & (ex_op[11:7] != '0);
      end else begin
        wb_en <= 1'b0;
      end

      redirect_valid <= take_jump;
      if (take_jump) begin
        redirect_pc <= alu_not_relative_pc ? alu_jump_offset
                                           : ex_pc + alu_jump_offset + INSTR_LENGTH'(4);
      end

      if (take_jump)
        flush_cnt <= CNT_W'(FLUSH_INIT);
      else if (state == FLUSH && !redirect_valid && flush_cnt != '0)
        flush_cnt <= flush_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed-vector bench for exec_sequencer: reset redirect, RAW stall, x0 writes,
// branch and JALR redirects with flush, and error halt.
module tb_exec_sequencer;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1_5 = 32'h0050_0093;
  localparam logic [31:0] ADD_X2_X1 = 32'h0010_8133;
  localparam logic [31:0] ADDI_X0_1 = 32'h0010_0013;
  localparam logic [31:0] ADD_X2_X0 = 32'h0000_0133;
  localparam logic [31:0] BEQ_16    = 32'h0000_0863;
  localparam logic [31:0] JALR_X1   = 32'h0001_00E7;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        ex_valid;
  logic [31:0] ex_op;
  logic [31:0] ex_pc;
  logic        alu_pc_jump;
  logic        alu_not_relative_pc;
  logic [31:0] alu_jump_offset;
  logic        alu_w_mem;
  logic [1:0]  alu_err;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  exec_sequencer #(
    .INSTR_LENGTH (32),
    .FLUSH_CYCLES (2),
    .RESET_PC     (32'h0000_0100)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .if_valid            (if_valid),
    .if_instr            (if_instr),
    .if_pc               (if_pc),
    .if_ready            (if_ready),
    .ex_valid            (ex_valid),
    .ex_op               (ex_op),
    .ex_pc               (ex_pc),
    .alu_pc_jump         (alu_pc_jump),
    .alu_not_relative_pc (alu_not_relative_pc),
    .alu_jump_offset     (alu_jump_offset),
    .alu_w_mem           (alu_w_mem),
    .alu_err             (alu_err),
    .wb_en               (wb_en),
    .wb_rd               (wb_rd),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .halted              (halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    if_valid = v;
    if_instr = instr;
    if_pc    = pc;
  endtask

  task automatic alu(input logic jump, input logic nrel, input logic [31:0] off,
                     input logic w, input logic [1:0] err);
    alu_pc_jump         = jump;
    alu_not_relative_pc = nrel;
    alu_jump_offset     = off;
    alu_w_mem           = w;
    alu_err             = err;
  endtask

  initial begin
    rst = 1'b1;
    fetch(1'b0, '0, '0);
    alu(1'b0, 1'b0, '0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // c0: first cycle after reset release
    check_eq("rst_redir_valid", redirect_valid, 1);
    check_eq("rst_redir_pc", redirect_pc, 32'h100);
    check_eq("rst_if_ready", if_ready, 0);
    check_eq("rst_ex_valid", ex_valid, 0);
    check_eq("rst_ex_op", ex_op, NOP);
    check_eq("rst_ex_pc", ex_pc, 0);
    check_eq("rst_wb_en", wb_en, 0);
    check_eq("rst_wb_rd", wb_rd, 0);
    check_eq("rst_halted", halted, 0);

    tick(); fetch(1'b1, ADDI_X1_5, 32'h0); #1;  // c1 flush
    check_eq("c1_redir_valid", redirect_valid, 0);
    check_eq("c1_if_ready", if_ready, 1);
    tick(); #1;                                 // c2 flush
    check_eq("c2_ex_valid", ex_valid, 0);
    check_eq("c2_if_ready", if_ready, 1);
    tick(); fetch(1'b1, ADDI_X1_5, 32'h10); #1; // c3 run
    check_eq("c3_ex_valid", ex_valid, 0);
    check_eq("c3_if_ready", if_ready, 1);

    tick(); fetch(1'b1, ADD_X2_X1, 32'h14); alu(1'b0, 1'b0, '0, 1'b1, 2'b00); #1; // c4
    check_eq("c4_ex_valid", ex_valid, 1);
    check_eq("c4_ex_op", ex_op, ADDI_X1_5);
    check_eq("c4_ex_pc", ex_pc, 32'h10);
    check_eq("c4_stall", if_ready, 0);
    tick(); #1;                                 // c5
    check_eq("c5_ex_valid", ex_valid, 0);
    check_eq("c5_ex_op", ex_op, NOP);
    check_eq("c5_wb_en", wb_en, 1);
    check_eq("c5_wb_rd", wb_rd, 1);
    check_eq("c5_if_ready", if_ready, 1);

    tick(); fetch(1'b1, ADDI_X0_1, 32'h18); alu(1'b0, 1'b0, '0, 1'b1, 2'b10); #1; // c6
    check_eq("c6_ex_op", ex_op, ADD_X2_X1);
    check_eq("c6_ex_pc", ex_pc, 32'h14);
    check_eq("c6_wb_en", wb_en, 0);
    check_eq("c6_if_ready", if_ready, 1);
    tick(); fetch(1'b1, ADD_X2_X0, 32'h1C); alu(1'b0, 1'b0, '0, 1'b1, 2'b00); #1; // c7
    check_eq("c7_wb_en", wb_en, 1);
    check_eq("c7_wb_rd", wb_rd, 2);
    check_eq("c7_ex_op", ex_op, ADDI_X0_1);
    check_eq("c7_if_ready", if_ready, 1);
    tick(); fetch(1'b1, BEQ_16, 32'h40); #1;    // c8
    check_eq("c8_x0_wb_en", wb_en, 0);
    check_eq("c8_ex_op", ex_op, ADD_X2_X0);
    check_eq("c8_if_ready", if_ready, 1);

    tick(); fetch(1'b1, ADDI_X1_5, 32'h44); alu(1'b1, 1'b0, 32'h0C, 1'b0, 2'b00); #1; // c9
    check_eq("c9_wb_en", wb_en, 1);
    check_eq("c9_ex_pc", ex_pc, 32'h40);
    check_eq("c9_jump_if_ready", if_ready, 0);
    tick(); fetch(1'b1, ADDI_X1_5, 32'h50); alu(1'b0, 1'b0, '0, 1'b0, 2'b00); #1; // c10
    check_eq("beq_redir_valid", redirect_valid, 1);
    check_eq("beq_redir_pc", redirect_pc, 32'h50);
    check_eq("c10_ex_valid", ex_valid, 0);
    check_eq("c10_wb_en", wb_en, 0);
    check_eq("c10_if_ready", if_ready, 0);
    tick(); fetch(1'b1, ADDI_X1_5, 32'h54); #1; // c11 flush
    check_eq("c11_redir_valid", redirect_valid, 0);
    check_eq("c11_if_ready", if_ready, 1);
    tick(); fetch(1'b1, ADDI_X1_5, 32'h58); #1; // c12 flush
    check_eq("c12_discard", ex_valid, 0);
    tick(); fetch(1'b1, JALR_X1, 32'h60); #1;   // c13 run
    check_eq("c13_discard", ex_valid, 0);
    check_eq("c13_if_ready", if_ready, 1);

    tick(); fetch(1'b0, '0, '0); alu(1'b1, 1'b1, 32'h2000, 1'b1, 2'b00); #1; // c14
    check_eq("c14_ex_op", ex_op, JALR_X1);
    check_eq("c14_if_ready", if_ready, 0);
    tick(); alu(1'b0, 1'b0, '0, 1'b0, 2'b00); #1; // c15
    check_eq("jalr_redir_valid", redirect_valid, 1);
    check_eq("jalr_redir_pc", redirect_pc, 32'h2000);
    check_eq("jalr_wb_en", wb_en, 1);
    check_eq("jalr_wb_rd", wb_rd, 1);
    tick(); #1;                                 // c16
    check_eq("c16_if_ready", if_ready, 1);
    tick(); #1;                                 // c17
    check_eq("c17_if_ready", if_ready, 1);
    tick(); fetch(1'b1, ADDI_X1_5, 32'h2000); #1; // c18
    check_eq("c18_if_ready", if_ready, 1);

    tick(); fetch(1'b1, ADD_X2_X0, 32'h2004); alu(1'b1, 1'b0, 32'h8, 1'b1, 2'b01); #1; // c19
    check_eq("c19_ex_valid", ex_valid, 1);
    check_eq("c19_err_if_ready", if_ready, 0);
    tick(); alu(1'b0, 1'b0, '0, 1'b0, 2'b00); #1; // c20
    check_eq("err_halted", halted, 1);
    check_eq("err_no_redir", redirect_valid, 0);
    check_eq("err_no_wb", wb_en, 0);
    check_eq("err_ex_valid", ex_valid, 0);
    check_eq("err_if_ready", if_ready, 0);
    tick(); #1;                                 // c21
    check_eq("c21_halted", halted, 1);
    check_eq("c21_ex_valid", ex_valid, 0);

    fetch(1'b0, '0, '0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_eq("rst2_halted", halted, 0);
    check_eq("rst2_redir_valid", redirect_valid, 1);
    check_eq("rst2_redir_pc", redirect_pc, 32'h100);
    check_eq("rst2_ex_valid", ex_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
